// File: rtl/sqrt_iter_hs_if.sv
// Handshake bundle for the iterative square-root engine: operand channel in, result channel out.
interface sqrt_iter_hs_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned HW = WIDTH / 2;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic             round;
    logic             out_valid;
    logic             out_ready;
    logic [HW-1:0]    y;
    logic [HW:0]      rem;
    logic             sat;

    modport master (
        output in_valid, x, round, out_ready,
        input  in_ready, out_valid, y, rem, sat
    );

    modport slave (
        input  in_valid, x, round, out_ready,
        output in_ready, out_valid, y, rem, sat
    );
endinterface

// File: rtl/sqrt_iter_hs.sv
// Iterative integer square root, non-restoring digit recurrence, BPC root bits per clock,
// valid/ready on both sides. Produces floor or rounded root plus the floor remainder.
module sqrt_iter_hs #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input logic           clk,
    input logic           reset,
    sqrt_iter_hs_if.slave bus
);
    localparam int unsigned HW   = WIDTH / 2;
    localparam int unsigned ITER = HW / BPC;
    localparam int unsigned CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             rnd_q, rnd_d;
    logic [HW-1:0]    root_q, root_d;
    logic [HW+1:0]    trem_q, trem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    y_q, y_d;
    logic [HW:0]      rem_q, rem_d;
    logic             sat_q, sat_d;

    logic [WIDTH-1:0] x_s;
    logic [HW-1:0]    root_s;
    logic [HW+1:0]    trem_s;
    logic [HW:0]      trem_fix;
    logic [1:0]       pair;
    logic             round_up;

    // Trial remainder is two's complement; its sign picks subtract vs add for the next digit.
    always_comb begin
        x_s    = x_q;
        root_s = root_q;
        trem_s = trem_q;
        pair   = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            pair = x_s[WIDTH-1 -: 2];
            x_s  = x_s << 2;
            if (!trem_s[HW+1]) begin
                trem_s = {trem_s[HW-1:0], pair} - {root_s, 2'b01};
            end else begin
                trem_s = {trem_s[HW-1:0], pair} + {root_s, 2'b11};
            end
            root_s = {root_s[HW-2:0], ~trem_s[HW+1]};
        end
        // Final restore step; the corrected remainder is non-negative and fits HW+1 bits.
        trem_fix = trem_s[HW+1] ? (trem_s[HW:0] + {root_s, 1'b1}) : trem_s[HW:0];
        round_up = rnd_q && (trem_fix > {1'b0, root_s});
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        rnd_d   = rnd_q;
        root_d  = root_q;
        trem_d  = trem_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    x_d     = bus.x;
                    rnd_d   = bus.round;
                    root_d  = '0;
                    trem_d  = '0;
                    cnt_d   = CW'(ITER);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                x_d    = x_s;
                root_d = root_s;
                trem_d = trem_s;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                    rem_d   = trem_fix;
                    sat_d   = round_up && (&root_s);
                    if (round_up && !(&root_s)) begin
                        y_d = root_s + HW'(1);
                    end else begin
                        y_d = root_s;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            rnd_q   <= 1'b0;
            root_q  <= '0;
            trem_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rnd_q   <= rnd_d;
            root_q  <= root_d;
            trem_q  <= trem_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.y         = y_q;
    assign bus.rem       = rem_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_sqrt_iter_hs.sv
// Bench for sqrt_iter_hs: four instances (WIDTH 32/16 x BPC 1/2) checked against an arithmetic model.
module tb_sqrt_iter_hs;
    logic        clk;
    logic        reset;
    logic        tin_valid  [4];
    logic [31:0] tx         [4];
    logic        tround     [4];
    logic        tout_ready [4];
    logic        tin_ready  [4];
    logic        tout_valid [4];
    logic [31:0] ty         [4];
    logic [31:0] trem       [4];
    logic        tsat       [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned W = (g < 2) ? 32 : 16;
        localparam int unsigned B = (g % 2) + 1;
        sqrt_iter_hs_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = tin_valid[g];
        assign bus.x         = tx[g][W-1:0];
        assign bus.round     = tround[g];
        assign bus.out_ready = tout_ready[g];
        assign tin_ready[g]  = bus.in_ready;
        assign tout_valid[g] = bus.out_valid;
        assign ty[g]         = 32'(bus.y);
        assign trem[g]       = 32'(bus.rem);
        assign tsat[g]       = bus.sat;
        sqrt_iter_hs #(.WIDTH(W), .BPC(B)) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hw_of(input int k);
        return (k < 2) ? 16 : 8;
    endfunction

    function automatic int iter_of(input int k);
        return hw_of(k) / ((k % 2) + 1);
    endfunction

    // Reference: exact integer sqrt by search around a real-valued estimate.
    function automatic void model(input logic [31:0] xv, input logic rv, input int hw,
                                  output logic [31:0] ey, output logic [31:0] er,
                                  output logic es);
        longint unsigned xx, f, r, top;
        xx = 64'(xv);
        f  = 64'($rtoi($sqrt(real'(xx))));
        while (f * f > xx) f--;
        while ((f + 1) * (f + 1) <= xx) f++;
        r   = xx - f * f;
        top = 64'(1) << hw;
        ey  = 32'(f);
        er  = 32'(r);
        es  = 1'b0;
        if (rv && r > f) begin
            if (f + 1 == top) begin
                ey = 32'(top - 1);
                es = 1'b1;
            end else begin
                ey = 32'(f + 1);
            end
        end
    endfunction

    task automatic run_op(input int k, input logic [31:0] xv, input logic rv, input int stall,
                          output logic [31:0] yo, output logic [31:0] ro, output logic so,
                          output int lat);
        int guard;
        @(negedge clk);
        tin_valid[k] = 1'b1;
        tx[k]        = xv;
        tround[k]    = rv;
        guard = 0;
        while (!tin_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        tin_valid[k] = 1'b0;
        lat = 0;
        while (!tout_valid[k] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!tout_valid[k]) lat = -1;
        yo = ty[k];
        ro = trem[k];
        so = tsat[k];
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        tout_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        tout_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tin_ready[k] !== 1'b1 || tout_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hs k=%0d got in_ready=%b out_valid=%b want 1 0",
                         k, tin_ready[k], tout_valid[k]);
            end
            checks++;
            if (ty[k] !== 32'd0 || trem[k] !== 32'd0 || tsat[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out k=%0d got y=%0d rem=%0d sat=%b want 0 0 0",
                         k, ty[k], trem[k], tsat[k]);
            end
        end
    endtask

    task automatic test_floor();
        logic [31:0] xs [4] = '{32'd1, 32'd3, 32'd4, 32'd0};
        logic [31:0] ys [4] = '{32'd1, 32'd1, 32'd2, 32'd0};
        logic [31:0] rs [4] = '{32'd0, 32'd2, 32'd0, 32'd0};
        logic [31:0] yo, ro;
        logic        so;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(0, xs[i], 1'b0, 0, yo, ro, so, lat);
            checks++;
            if (yo !== ys[i]) begin
                errors++;
                $display("FAIL floor_y x=%0d got %0d want %0d", xs[i], yo, ys[i]);
            end
            checks++;
            if (ro !== rs[i]) begin
                errors++;
                $display("FAIL floor_rem x=%0d got %0d want %0d", xs[i], ro, rs[i]);
            end
            checks++;
            if (lat != 16) begin
                errors++;
                $display("FAIL floor_latency x=%0d got %0d want 16", xs[i], lat);
            end
        end
    endtask

    task automatic test_round();
        logic [31:0] xs [4] = '{32'd6, 32'd7, 32'd12, 32'hffff_ffff};
        logic [31:0] ys [4] = '{32'd2, 32'd3, 32'd3, 32'd65535};
        logic [31:0] rs [4] = '{32'd2, 32'd3, 32'd3, 32'd131070};
        logic        ss [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] yo, ro;
        logic        so;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(0, xs[i], 1'b1, 1, yo, ro, so, lat);
            checks++;
            if (yo !== ys[i] || ro !== rs[i] || so !== ss[i]) begin
                errors++;
                $display("FAIL round x=%0d got y=%0d rem=%0d sat=%b want %0d %0d %b",
                         xs[i], yo, ro, so, ys[i], rs[i], ss[i]);
            end
            checks++;
            if (lat != 16) begin
                errors++;
                $display("FAIL round_latency x=%0d got %0d want 16", xs[i], lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        tin_valid[0] = 1'b1;
        tx[0]        = 32'd1000003;
        tround[0]    = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        while (!tout_valid[0] && lat < 100) begin
            tx[0] = ~tx[0];
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 16) begin
            errors++;
            $display("FAIL bp_latency got %0d want 16", lat);
        end
        for (int c = 0; c < 10; c++) begin
            tx[0] = ~tx[0];
            @(posedge clk);
            #1;
            checks++;
            if (ty[0] !== 32'd1000 || trem[0] !== 32'd3 || tin_ready[0] !== 1'b0 ||
                tout_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c=%0d got y=%0d rem=%0d in_ready=%b out_valid=%b want 1000 3 0 1",
                         c, ty[0], trem[0], tin_ready[0], tout_valid[0]);
            end
        end
        // Handoff with in_valid still high: the new operand must wait one IDLE cycle.
        tx[0]         = 32'd49;
        tout_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        tout_ready[0] = 1'b0;
        checks++;
        if (tout_valid[0] !== 1'b0 || tin_ready[0] !== 1'b1 || ty[0] !== 32'd1000) begin
            errors++;
            $display("FAIL bp_handoff got out_valid=%b in_ready=%b y=%0d want 0 1 1000",
                     tout_valid[0], tin_ready[0], ty[0]);
        end
        @(posedge clk);
        #1;
        tin_valid[0] = 1'b0;
        checks++;
        if (tin_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got in_ready=%b want 0", tin_ready[0]);
        end
        lat = 0;
        while (!tout_valid[0] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (ty[0] !== 32'd7 || trem[0] !== 32'd0 || lat != 16) begin
            errors++;
            $display("FAIL bp_next got y=%0d rem=%0d lat=%0d want 7 0 16", ty[0], trem[0], lat);
        end
        tout_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        tout_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] yo, ro;
        logic        so;
        int          lat;
        @(negedge clk);
        tin_valid[0] = 1'b1;
        tx[0]        = 32'd12345678;
        tround[0]    = 1'b0;
        @(posedge clk);
        #1;
        tin_valid[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (tout_valid[0] !== 1'b0 || tin_ready[0] !== 1'b1 || ty[0] !== 32'd0) begin
            errors++;
            $display("FAIL midreset got out_valid=%b in_ready=%b y=%0d want 0 1 0",
                     tout_valid[0], tin_ready[0], ty[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op(0, 32'd100, 1'b0, 0, yo, ro, so, lat);
        checks++;
        if (yo !== 32'd10 || ro !== 32'd0 || lat != 16) begin
            errors++;
            $display("FAIL midreset_next got y=%0d rem=%0d lat=%0d want 10 0 16", yo, ro, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] xv, yo, ro, ey, er;
        logic        rv, so, es;
        int          lat, hw;
        for (int k = 0; k < 4; k++) begin
            hw = hw_of(k);
            for (int i = 0; i < 125; i++) begin
                xv = $urandom();
                if (i == 0) xv = 32'd0;
                if (i == 1) xv = 32'hffff_ffff;
                if (hw == 8) xv = xv & 32'h0000_ffff;
                rv = 1'($urandom_range(0, 1));
                run_op(k, xv, rv, int'($urandom_range(0, 3)), yo, ro, so, lat);
                model(xv, rv, hw, ey, er, es);
                checks++;
                if (yo !== ey || ro !== er || so !== es) begin
                    errors++;
                    $display("FAIL rand k=%0d x=%0d rnd=%b got y=%0d rem=%0d sat=%b want %0d %0d %b",
                             k, xv, rv, yo, ro, so, ey, er, es);
                end
                checks++;
                if (lat != iter_of(k)) begin
                    errors++;
                    $display("FAIL rand_latency k=%0d got %0d want %0d", k, lat, iter_of(k));
                end
                if (!rv) begin
                    checks++;
                    if (64'(yo) * 64'(yo) + 64'(ro) != 64'(xv) || ro > 2 * yo) begin
                        errors++;
                        $display("FAIL rand_identity k=%0d x=%0d got y=%0d rem=%0d", k, xv, yo, ro);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tin_valid[i]  = 1'b0;
            tx[i]         = '0;
            tround[i]     = 1'b0;
            tout_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_floor();
        test_round();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
